// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART packet transmitter.
package uart_pkt_pkg;

  // Frame sequencer states: one start bit, eight data bits, one stop bit.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Start + 8 data + stop.
  localparam int BITS_PER_FRAME = 10;

  // Sensor-link sync pattern, MSB byte first on the wire.
  localparam logic [15:0] DEFAULT_HEADER = 16'h55AA;

endpackage

// File: rtl/uart_packet_tx_if.sv
// Packet handshake between the processing datapath and the transmitter.
interface uart_packet_tx_if #(
  parameter int PAYLOAD_BYTES = 6
);

  logic [8*PAYLOAD_BYTES-1:0] pkt_data;
  logic                       pkt_valid;
  logic                       pkt_ready;

  modport master (output pkt_data, output pkt_valid, input pkt_ready);
  modport slave  (input pkt_data, input pkt_valid, output pkt_ready);

endinterface

// File: rtl/uart_packet_tx_baud_tick.sv
// Bit-period timer: tick is high on the last clock cycle of every bit.
// clear restarts the period so the first bit of a packet is full length.
module uart_baud_tick #(
  parameter int CLK_DIV = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_r;

  // Count clock cycles within one bit, wrapping at the end of the bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (count_r == LAST) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + CW'(1);
    end
  end

  assign tick = (count_r == LAST);

endmodule

// File: rtl/uart_packet_tx.sv
// Serial packet transmitter: header bytes, payload bytes (highest first) and,
// when UART_PKT_CHECKSUM_EN is defined, a mod-256 checksum byte, each sent
// as an 8N1 UART frame with no gap between frames of one packet.
module uart_packet_tx
  import uart_pkt_pkg::*;
#(
  parameter int                       CLK_DIV       = 16,
  parameter int                       PAYLOAD_BYTES = 6,
  parameter int                       HDR_BYTES     = 2,
  parameter logic [8*HDR_BYTES-1:0]   HEADER        = DEFAULT_HEADER
) (
  input  logic                clock,
  input  logic                reset,
  uart_packet_tx_if.slave     pkt_if,
  output logic                tx,
  output logic                busy,
  output logic                done
);

`ifdef UART_PKT_CHECKSUM_EN
  localparam int NBYTES = HDR_BYTES + PAYLOAD_BYTES + 1;
`else
  localparam int NBYTES = HDR_BYTES + PAYLOAD_BYTES;
`endif
  localparam int BW = $clog2(NBYTES + 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);
  // Index of the final data bit: frame minus start, stop and one.
  localparam logic [2:0] LAST_DATA_BIT = 3'(BITS_PER_FRAME - 3);

`ifdef UART_PKT_CHECKSUM_EN
  // Sum mod 256 of every byte ahead of the checksum slot.
  function automatic logic [7:0] byte_sum(input logic [8*(NBYTES-1)-1:0] v);
    logic [7:0] s;
    s = 8'd0;
    for (int k = 0; k < NBYTES - 1; k++) begin
      s = s + v[8*k +: 8];
    end
    return s;
  endfunction
`endif

  state_t              state_r;
  logic [BW-1:0]       byte_idx_r;
  logic [2:0]          bit_idx_r;
  logic [8*NBYTES-1:0] buf_r;      // byte 0 (first on the wire) in bits [7:0]
  logic                tx_r;
  logic                busy_r;
  logic                done_r;

  logic [8*NBYTES-1:0] load_s;
  logic [7:0]          cur_byte_s;
  logic                accept_s;
  logic                tick_s;

  assign accept_s = pkt_if.pkt_valid && (state_r == IDLE);

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
    .clock (clock),
    .reset (reset),
    .clear (accept_s),
    .tick  (tick_s)
  );

  // Arrange header and payload into transmit order for latching on accept.
  always_comb begin
    load_s = '0;
    for (int i = 0; i < HDR_BYTES; i++) begin
      load_s[8*i +: 8] = HEADER[8*(HDR_BYTES-1-i) +: 8];
    end
    for (int j = 0; j < PAYLOAD_BYTES; j++) begin
      load_s[8*(HDR_BYTES+j) +: 8] = pkt_if.pkt_data[8*(PAYLOAD_BYTES-1-j) +: 8];
    end
`ifdef UART_PKT_CHECKSUM_EN
    load_s[8*(NBYTES-1) +: 8] = byte_sum(load_s[8*(NBYTES-1)-1:0]);
`endif
  end

  // Select the byte currently being framed.
  always_comb begin
    cur_byte_s = buf_r[8*byte_idx_r +: 8];
  end

  // Frame sequencer with registered line and status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      byte_idx_r <= '0;
      bit_idx_r  <= 3'd0;
      buf_r      <= '0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r    <= START;
            buf_r      <= load_s;
            byte_idx_r <= '0;
            bit_idx_r  <= 3'd0;
            tx_r       <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        START: begin
          if (tick_s) begin
            state_r   <= DATA;
            bit_idx_r <= 3'd0;
            tx_r      <= cur_byte_s[0];
          end
        end
        DATA: begin
          if (tick_s) begin
            if (bit_idx_r == LAST_DATA_BIT) begin
              state_r <= STOP;
              tx_r    <= 1'b1;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= cur_byte_s[bit_idx_r + 3'd1];
            end
          end
        end
        STOP: begin
          if (tick_s) begin
            if (byte_idx_r == LAST_BYTE) begin
              state_r    <= IDLE;
              byte_idx_r <= '0;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
            end else begin
              state_r    <= START;
              byte_idx_r <= byte_idx_r + BW'(1);
              tx_r       <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign pkt_if.pkt_ready = (state_r == IDLE);
  assign tx   = tx_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: doc/uart_packet_tx.md
Name: uart_packet_tx

Overview:
Parametrised serial packet transmitter for the AGV sensor link. It frames a fixed header plus an N-byte processed-data payload into standard UART frames: 1 start bit, 8 data bits LSB-first, 1 stop bit, at a programmable clocks-per-bit rate. It adds a valid/ready handshake, busy and done status, and an optional checksum byte. It sits between the LiDAR processing datapath and the board TX pin.

Parameters:
CLK_DIV, 16, clock cycles per UART bit; must be >= 2.
PAYLOAD_BYTES, 6, number of payload bytes per packet; must be >= 1.
HDR_BYTES, 2, number of header bytes; must be >= 1.
HEADER, 16'h55AA, header value; width 8*HDR_BYTES; most significant byte is sent first.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
pkt_data  in  8*PAYLOAD_BYTES  payload; byte [8*PAYLOAD_BYTES-1 -: 8] is sent first
pkt_valid  in  1  request to send pkt_data
pkt_ready  out  1  high when a new packet can be accepted
tx  out  1  serial line; idle high
busy  out  1  packet in progress
done  out  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Reset (asynchronous, immediate): tx=1, busy=0, pkt_ready=1, done=0, state=IDLE, all counters 0. A reset mid-packet aborts the packet and discards it; there is no partial resend.
- pkt_ready = (state==IDLE). Accept occurs on a clock edge where pkt_valid && pkt_ready. pkt_valid while not ready is ignored and pkt_data is not sampled.
- On accept, the payload and header are latched into an internal byte buffer. pkt_data may change afterwards.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on accept. From that edge: tx=0, busy=1, pkt_ready=0.
  - START -> DATA after CLK_DIV cycles.
  - DATA -> STOP after 8 bits of CLK_DIV cycles each; byte bits are sent b0 first.
  - STOP drives tx=1 for CLK_DIV cycles. At the end: if bytes remain, go to START for the next byte; otherwise go to IDLE with done=1 for one cycle, busy=0, pkt_ready=1.
- Every bit lasts exactly CLK_DIV cycles. There is no idle gap between consecutive frames of one packet.
- Byte order: HEADER MSB byte … HEADER LSB byte, then payload from the highest byte down, then the checksum if enabled.
- Total busy time = NBYTES*10*CLK_DIV cycles, where NBYTES = HDR_BYTES+PAYLOAD_BYTES(+1 with checksum).
- Back-to-back packets: pkt_valid may be held high. The next packet is accepted on the done cycle, which is an IDLE cycle. tx is 1 for that one cycle, then the next start bit begins.
- Counters:
  - baud counter: $clog2(CLK_DIV) bits, wraps at CLK_DIV-1.
  - bit index: 3 bits.
  - byte index: $clog2(NBYTES+1) bits.
- All outputs are registered except pkt_ready, which is decoded from the state register.

Optional Feature:
Macro UART_PKT_CHECKSUM_EN.
- Defined: one extra byte is appended after the payload. It equals the sum mod 256 of all header and payload bytes, and is computed at accept time from the latched values. The byte buffer holds NBYTES entries.
- Undefined: no checksum byte and no adder logic; the packet ends after the last payload byte.

Decomposition:
- Package uart_pkt_pkg: state enum (IDLE/START/DATA/STOP), BITS_PER_FRAME=10, DEFAULT_HEADER=16'h55AA.
- Sub-module uart_baud_tick (parameter CLK_DIV; ports clock, reset, clear, tick). Emits tick on the last cycle of each bit; clear restarts the count on accept.

Test Plan:
1. Reset behaviour: assert reset for 3 cycles -> tx=1, busy=0, pkt_ready=1, done=0. Assert reset 50 cycles into a packet -> tx=1 and busy=0 immediately; a subsequent packet is sent cleanly.
2. Basic packet (CLK_DIV=4, PAYLOAD_BYTES=2, HEADER=16'h55AA, pkt_data=16'h1234, no checksum): decode the tx line -> bytes 55 AA 12 34. First frame bit sequence is 0,1,0,1,0,1,0,1,0,1. busy high for 160 cycles; done pulses once.
3. Checksum build (same stimulus): decoded bytes are 55 AA 12 34 45; busy high for 200 cycles.
4. Handshake: pulse pkt_valid while busy with pkt_data=16'hFFFF -> ignored, no second packet. Change pkt_data mid-packet -> transmitted payload is unchanged.
5. Back-to-back: hold pkt_valid=1 across two packets -> the second accept coincides with done, exactly 1 idle-high cycle between packets, both packets decode correctly.
6. Default parameters (CLK_DIV=16, PAYLOAD_BYTES=6): random payload, receiver model checks 8 bytes, 1280 busy cycles, and each bit width is 16 cycles.
